// File: rtl/jacobi_result_tx.sv
// jacobi_result_tx: streams the N-entry Jacobi solution vector out of the
// shared solution RAM, one word at a time, with a drdy/dack handshake.
// Each word takes a READ cycle (address out), a WAIT cycle (RAM latency),
// then a SHOW state held until the consumer acknowledges.
// Optional build macro: JACOBI_TX_CSUM_EN appends a trailing word that holds
// the 32-bit wrap-around sum of every word sent in the stream.
module jacobi_result_tx #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 16,
   parameter int N_W    = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [N_W-1:0]    n,
   input  logic [ADDR_W-1:0] base_addr,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [DATA_W-1:0] rd_data,
   output logic [DATA_W-1:0] dout,
   output logic              drdy,
   input  logic              dack,
   output logic              busy,
   output logic              done
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ,
      S_WAIT,
      S_SHOW,
      S_DONE
`ifdef JACOBI_TX_CSUM_EN
      , S_CSUM
`endif
   } state_t;

   state_t              state_q, state_d;
   logic [N_W-1:0]      n_q, n_d;
   logic [ADDR_W-1:0]   base_q, base_d;
   logic [N_W-1:0]      idx_q, idx_d;
   logic [DATA_W-1:0]   dout_q, dout_d;
`ifdef JACOBI_TX_CSUM_EN
   logic [DATA_W-1:0]   sum_q, sum_d;
`endif

   // State and datapath registers; reset aborts any stream in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         n_q     <= '0;
         base_q  <= '0;
         idx_q   <= '0;
         dout_q  <= '0;
`ifdef JACOBI_TX_CSUM_EN
         sum_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         n_q     <= n_d;
         base_q  <= base_d;
         idx_q   <= idx_d;
         dout_q  <= dout_d;
`ifdef JACOBI_TX_CSUM_EN
         sum_q   <= sum_d;
`endif
      end
   end

   // Next-state logic: sequencing of read, capture and handshake per word.
   always_comb begin
      state_d = state_q;
      n_d     = n_q;
      base_d  = base_q;
      idx_d   = idx_q;
      dout_d  = dout_q;
`ifdef JACOBI_TX_CSUM_EN
      sum_d   = sum_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (start) begin
`ifdef JACOBI_TX_CSUM_EN
               sum_d = '0;
`endif
               if (n != '0) begin
                  n_d     = n;
                  base_d  = base_addr;
                  idx_d   = '0;
                  state_d = S_READ;
               end else begin
                  // Empty vector: no reads, just signal completion
                  // (or send the zero checksum first).
`ifdef JACOBI_TX_CSUM_EN
                  dout_d  = '0;
                  state_d = S_CSUM;
`else
                  state_d = S_DONE;
`endif
               end
            end
         end
         S_READ: state_d = S_WAIT;
         S_WAIT: begin
            // RAM data is valid exactly one cycle after the read strobe.
            dout_d  = rd_data;
            state_d = S_SHOW;
         end
         S_SHOW: begin
            if (dack) begin
`ifdef JACOBI_TX_CSUM_EN
               sum_d = sum_q + dout_q;
`endif
               if (idx_q == (n_q - N_W'(1))) begin
`ifdef JACOBI_TX_CSUM_EN
                  dout_d  = sum_q + dout_q;
                  state_d = S_CSUM;
`else
                  state_d = S_DONE;
`endif
               end else begin
                  idx_d   = idx_q + N_W'(1);
                  state_d = S_READ;
               end
            end
         end
`ifdef JACOBI_TX_CSUM_EN
         S_CSUM: begin
            if (dack) state_d = S_DONE;
         end
`endif
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs decode directly from the state so reset clears them at once.
   assign rd_en   = (state_q == S_READ);
   assign rd_addr = base_q + ADDR_W'(idx_q);
   assign dout    = dout_q;
   assign done    = (state_q == S_DONE);
`ifdef JACOBI_TX_CSUM_EN
   assign drdy    = (state_q == S_SHOW) || (state_q == S_CSUM);
   assign busy    = (state_q == S_READ) || (state_q == S_WAIT) ||
                    (state_q == S_SHOW) || (state_q == S_CSUM);
`else
   assign drdy    = (state_q == S_SHOW);
   assign busy    = (state_q == S_READ) || (state_q == S_WAIT) ||
                    (state_q == S_SHOW);
`endif

endmodule
